eth_game_rx: RTL and testbench

// - RMII receive stage pairing with the game-state transmitter: consumes eth_crsdv/eth_rxd dibits, finds preamble+SFD,

---
 rtl/eth_game_rx.sv | 213 +++++++++++++++++++++
 tb/tb_eth_game_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_game_rx.sv
// RMII receive stage for the kart game link. It finds the preamble and SFD, rebuilds bytes,
// filters on the destination MAC and publishes the opponent state. Define CRC32_CHECK_EN to also require a good FCS.
module eth_game_rx #(
   parameter int          FRAME_BYTES = 56,
   parameter logic [47:0] DEST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter int          MIN_PRE     = 8
) (
   input  logic        eth_clk,
   input  logic        eth_rst,
   input  logic        eth_crsdv,
   input  logic [1:0]  eth_rxd,
   output logic [10:0] opp_x,
   output logic [10:0] opp_y,
   output logic [8:0]  opp_direction,
   output logic [2:0]  opp_game_stat,
   output logic        opp_rst,
   output logic        opp_valid,
   output logic        frame_err
);

   localparam int CW = $clog2(FRAME_BYTES + 1);
   localparam int PW = $clog2(MIN_PRE + 1);
   localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES);
   localparam logic [CW-1:0] MAC_END   = CW'(6);
   localparam logic [CW-1:0] PAY_START = CW'(14);
   localparam logic [CW-1:0] PAY_END   = CW'(20);
   localparam logic [PW-1:0] PRE_MIN   = PW'(MIN_PRE);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_BODY, S_CHECK, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic [1:0]    phase_q, phase_d;
   logic [5:0]    byte_sr_q, byte_sr_d;
   logic [47:0]   pay_q, pay_d;
   logic [10:0]   opp_x_q, opp_x_d, opp_y_q, opp_y_d;
   logic [8:0]    opp_dir_q, opp_dir_d;
   logic [2:0]    opp_stat_q, opp_stat_d;
   logic          opp_rst_q, opp_rst_d;
   logic          opp_valid_q, opp_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    byte_now;
   logic [7:0]    mac_byte;
   logic          frame_good;

`ifdef CRC32_CHECK_EN
   logic [31:0] crc_q, crc_d;
   logic        crc_ok;

   // Reflected CRC-32, two bits per clock, LSB of the dibit first.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++) begin
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
      end
      return r;
   endfunction

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   assign crc_ok = (bit_rev(crc_q) == 32'hC704_DD7B);
`endif

   assign byte_now = {eth_rxd, byte_sr_q};

   always_comb begin
      mac_byte = 8'h00;
      for (int i = 0; i < 6; i++) begin
         if (byte_cnt_q == CW'(i)) mac_byte = DEST_MAC[8*(5-i) +: 8];
      end
   end

`ifdef CRC32_CHECK_EN
   assign frame_good = (byte_cnt_q == LAST_BYTE) && (phase_q == 2'd0) && crc_ok;
`else
   assign frame_good = (byte_cnt_q == LAST_BYTE) && (phase_q == 2'd0);
`endif

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      phase_d     = phase_q;
      byte_sr_d   = byte_sr_q;
      pay_d       = pay_q;
      opp_x_d     = opp_x_q;
      opp_y_d     = opp_y_q;
      opp_dir_d   = opp_dir_q;
      opp_stat_d  = opp_stat_q;
      opp_rst_d   = opp_rst_q;
      opp_valid_d = 1'b0;
      frame_err_d = 1'b0;
`ifdef CRC32_CHECK_EN
      crc_d       = crc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (eth_crsdv && eth_rxd == 2'b01) begin
               state_d   = S_PRE;
               pre_cnt_d = PW'(1);
            end
         end
         S_PRE: begin
            if (!eth_crsdv) begin
               state_d = S_IDLE;
            end else if (eth_rxd == 2'b01) begin
               if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 1'b1;
            end else if (eth_rxd == 2'b11 && pre_cnt_q >= PRE_MIN) begin
               state_d    = S_BODY;
               phase_d    = 2'd0;
               byte_cnt_d = '0;
`ifdef CRC32_CHECK_EN
               crc_d      = '1;
`endif
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_BODY: begin
            if (!eth_crsdv) begin
               state_d = S_CHECK;
            end else if (byte_cnt_q == LAST_BYTE) begin
               state_d     = S_DRAIN;
               frame_err_d = 1'b1;
            end else begin
               phase_d   = phase_q + 2'd1;
               byte_sr_d = {eth_rxd, byte_sr_q[5:2]};
`ifdef CRC32_CHECK_EN
               crc_d     = crc_step(crc_q, eth_rxd);
`endif
               // A byte completes on its fourth dibit; filter and capture it right here.
               if (phase_q == 2'd3) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  if (byte_cnt_q < MAC_END && byte_now != mac_byte) state_d = S_DRAIN;
                  if (byte_cnt_q >= PAY_START && byte_cnt_q < PAY_END) pay_d = {pay_q[39:0], byte_now};
               end
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (frame_good) begin
               opp_x_d     = pay_q[47:37];
               opp_y_d     = pay_q[35:25];
               opp_dir_d   = pay_q[23:15];
               opp_stat_d  = pay_q[11:9];
               opp_rst_d   = pay_q[7];
               opp_valid_d = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (!eth_crsdv) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge eth_clk) begin
      if (eth_rst) begin
         state_q     <= S_IDLE;
         pre_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         phase_q     <= '0;
         byte_sr_q   <= '0;
         pay_q       <= '0;
         opp_x_q     <= '0;
         opp_y_q     <= '0;
         opp_dir_q   <= '0;
         opp_stat_q  <= '0;
         opp_rst_q   <= 1'b0;
         opp_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef CRC32_CHECK_EN
         crc_q       <= '1;
`endif
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         phase_q     <= phase_d;
         byte_sr_q   <= byte_sr_d;
         pay_q       <= pay_d;
         opp_x_q     <= opp_x_d;
         opp_y_q     <= opp_y_d;
         opp_dir_q   <= opp_dir_d;
         opp_stat_q  <= opp_stat_d;
         opp_rst_q   <= opp_rst_d;
         opp_valid_q <= opp_valid_d;
         frame_err_q <= frame_err_d;
`ifdef CRC32_CHECK_EN
         crc_q       <= crc_d;
`endif
      end
   end

   assign opp_x         = opp_x_q;
   assign opp_y         = opp_y_q;
   assign opp_direction = opp_dir_q;
   assign opp_game_stat = opp_stat_q;
   assign opp_rst       = opp_rst_q;
   assign opp_valid     = opp_valid_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_eth_game_rx.sv
// Directed bench for eth_game_rx: it builds RMII frames with a correct FCS and checks the
// published opponent state and the opp_valid/frame_err pulse counts for each scenario.
module tb_eth_game_rx;

   logic        eth_clk = 1'b0;
   logic        eth_rst;
   logic        eth_crsdv;
   logic [1:0]  eth_rxd;
   logic [10:0] opp_x, opp_y;
   logic [8:0]  opp_direction;
   logic [2:0]  opp_game_stat;
   logic        opp_rst, opp_valid, frame_err;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int v0, e0;
   logic [7:0] frame [0:55];

   eth_game_rx dut (
      .eth_clk(eth_clk), .eth_rst(eth_rst), .eth_crsdv(eth_crsdv), .eth_rxd(eth_rxd),
      .opp_x(opp_x), .opp_y(opp_y), .opp_direction(opp_direction), .opp_game_stat(opp_game_stat),
      .opp_rst(opp_rst), .opp_valid(opp_valid), .frame_err(frame_err)
   );

   always #10 eth_clk = ~eth_clk;

   // Pulse counters sampled on the falling edge, away from the register updates.
   always @(negedge eth_clk) begin
      if (opp_valid === 1'b1) valid_cnt++;
      if (frame_err === 1'b1) err_cnt++;
      if (opp_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
   end

   function automatic logic [31:0] crc32_bytes(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            if (c[0] ^ frame[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
            else c = c >> 1;
         end
      end
      return ~c;
   endfunction

   task automatic build_frame(input logic [47:0] dest, input logic [10:0] x, input logic [10:0] y,
                              input logic [8:0] dir, input logic [2:0] stat, input logic rst);
      logic [47:0] pay;
      logic [47:0] src;
      logic [31:0] fcs;
      pay = '0;
      pay[47:37] = x;
      pay[35:25] = y;
      pay[23:15] = dir;
      pay[11:9]  = stat;
      pay[7]     = rst;
      src = 48'h0200_0000_0002;
      for (int i = 0; i < 56; i++) frame[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         frame[i]      = dest[47-8*i -: 8];
         frame[6+i]    = src[47-8*i -: 8];
         frame[14+i]   = pay[47-8*i -: 8];
      end
      frame[12] = 8'h88;
      frame[13] = 8'hB5;
      fcs = crc32_bytes(52);
      for (int i = 0; i < 4; i++) frame[52+i] = fcs[8*i +: 8];
   endtask

   task automatic send_dibit(input logic [1:0] d);
      @(negedge eth_clk);
      eth_crsdv = 1'b1;
      eth_rxd   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge eth_clk);
         eth_crsdv = 1'b0;
         eth_rxd   = 2'b00;
      end
   endtask

   task automatic send_frame(input int nbytes, input int extra);
      repeat (28) send_dibit(2'b01);
      send_dibit(2'b11);
      for (int i = 0; i < nbytes; i++) begin
         for (int j = 0; j < 4; j++) send_dibit(frame[i][2*j +: 2]);
      end
      repeat (extra) send_dibit(2'b00);
   endtask

   task automatic test_reset();
      eth_rst = 1'b1; eth_crsdv = 1'b0; eth_rxd = 2'b00;
      repeat (4) @(negedge eth_clk);
      eth_rst = 1'b0;
      checks++; if (opp_x !== 11'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 0", opp_x); end
      checks++; if (opp_y !== 11'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 0", opp_y); end
      checks++; if (opp_direction !== 9'd0) begin errors++; $display("[TB] FAIL reset_dir: got %0d expected 0", opp_direction); end
      checks++; if ({opp_game_stat, opp_rst} !== 4'd0) begin errors++; $display("[TB] FAIL reset_stat_rst: got %0d/%0d expected 0/0", opp_game_stat, opp_rst); end
      checks++; if ({opp_valid, frame_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {opp_valid, frame_err}); end
      v0 = valid_cnt; e0 = err_cnt;
      idle(200);
      checks++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL quiet_line: got valid=%0d err=%0d expected 0/0", valid_cnt - v0, err_cnt - e0); end
   endtask

   task automatic test_good_frame();
      build_frame(48'hFFFF_FFFF_FFFF, 11'd300, 11'd150, 9'd270, 3'd5, 1'b0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(56, 0);
      idle(8);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("[TB] FAIL good_valid: got %0d pulses expected 1", valid_cnt - v0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL good_err: got %0d pulses expected 0", err_cnt - e0); end
      checks++; if (opp_x !== 11'd300) begin errors++; $display("[TB] FAIL good_x: got %0d expected 300", opp_x); end
      checks++; if (opp_y !== 11'd150) begin errors++; $display("[TB] FAIL good_y: got %0d expected 150", opp_y); end
      checks++; if (opp_direction !== 9'd270) begin errors++; $display("[TB] FAIL good_dir: got %0d expected 270", opp_direction); end
      checks++; if (opp_game_stat !== 3'd5) begin errors++; $display("[TB] FAIL good_stat: got %0d expected 5", opp_game_stat); end
      checks++; if (opp_rst !== 1'b0) begin errors++; $display("[TB] FAIL good_rst: got %0d expected 0", opp_rst); end
   endtask

   task automatic test_mac_filter();
      build_frame(48'h0200_0000_0001, 11'd7, 11'd8, 9'd9, 3'd1, 1'b1);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(56, 0);
      idle(8);
      checks++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL mac_pulses: got valid=%0d err=%0d expected 0/0", valid_cnt - v0, err_cnt - e0); end
      checks++; if (opp_x !== 11'd300 || opp_rst !== 1'b0) begin errors++; $display("[TB] FAIL mac_hold: got x=%0d rst=%0d expected 300/0", opp_x, opp_rst); end
   endtask

   task automatic test_length_errors();
      build_frame(48'hFFFF_FFFF_FFFF, 11'd11, 11'd22, 9'd33, 3'd2, 1'b1);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(40, 0);
      idle(8);
      checks++; if (err_cnt - e0 != 1 || valid_cnt - v0 != 0) begin errors++; $display("[TB] FAIL short_frame: got err=%0d valid=%0d expected 1/0", err_cnt - e0, valid_cnt - v0); end
      checks++; if (opp_x !== 11'd300) begin errors++; $display("[TB] FAIL short_hold: got x=%0d expected 300", opp_x); end
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(56, 1);
      idle(8);
      checks++; if (err_cnt - e0 != 1 || valid_cnt - v0 != 0) begin errors++; $display("[TB] FAIL long_frame: got err=%0d valid=%0d expected 1/0", err_cnt - e0, valid_cnt - v0); end
      checks++; if (opp_y !== 11'd150) begin errors++; $display("[TB] FAIL long_hold: got y=%0d expected 150", opp_y); end
   endtask

   task automatic test_reset_mid_frame();
      build_frame(48'hFFFF_FFFF_FFFF, 11'd100, 11'd200, 9'd45, 3'd2, 1'b1);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(20, 0);
      @(negedge eth_clk);
      eth_rst = 1'b1; eth_crsdv = 1'b0; eth_rxd = 2'b00;
      repeat (3) @(negedge eth_clk);
      eth_rst = 1'b0;
      idle(4);
      checks++; if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL abort_pulses: got valid=%0d err=%0d expected 0/0", valid_cnt - v0, err_cnt - e0); end
      checks++; if (opp_x !== 11'd0) begin errors++; $display("[TB] FAIL abort_clear: got x=%0d expected 0", opp_x); end
      send_frame(56, 0);
      idle(8);
      checks++; if (valid_cnt - v0 != 1 || err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL resend_pulses: got valid=%0d err=%0d expected 1/0", valid_cnt - v0, err_cnt - e0); end
      checks++; if (opp_x !== 11'd100 || opp_direction !== 9'd45 || opp_rst !== 1'b1) begin errors++; $display("[TB] FAIL resend_fields: got x=%0d dir=%0d rst=%0d expected 100/45/1", opp_x, opp_direction, opp_rst); end
   endtask

   task automatic test_back_to_back();
      build_frame(48'hFFFF_FFFF_FFFF, 11'd1023, 11'd2047, 9'd511, 3'd7, 1'b0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(56, 0);
      idle(2);
      build_frame(48'hFFFF_FFFF_FFFF, 11'd5, 11'd6, 9'd300, 3'd3, 1'b1);
      send_frame(56, 0);
      idle(8);
      checks++; if (valid_cnt - v0 != 2 || err_cnt - e0 != 0) begin errors++; $display("[TB] FAIL b2b_pulses: got valid=%0d err=%0d expected 2/0", valid_cnt - v0, err_cnt - e0); end
      checks++; if (opp_x !== 11'd5 || opp_y !== 11'd6 || opp_direction !== 9'd300 || opp_game_stat !== 3'd3) begin
         errors++; $display("[TB] FAIL b2b_fields: got %0d/%0d/%0d/%0d expected 5/6/300/3", opp_x, opp_y, opp_direction, opp_game_stat);
      end
   endtask

`ifdef CRC32_CHECK_EN
   task automatic test_crc();
      build_frame(48'hFFFF_FFFF_FFFF, 11'd77, 11'd88, 9'd99, 3'd4, 1'b0);
      frame[16] = frame[16] ^ 8'h10;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(56, 0);
      idle(8);
      checks++; if (err_cnt - e0 != 1 || valid_cnt - v0 != 0) begin errors++; $display("[TB] FAIL crc_bad: got err=%0d valid=%0d expected 1/0", err_cnt - e0, valid_cnt - v0); end
      checks++; if (opp_x !== 11'd5) begin errors++; $display("[TB] FAIL crc_hold: got x=%0d expected 5", opp_x); end
   endtask
`endif

   initial begin
      test_reset();
      test_good_frame();
      test_mac_filter();
      test_length_errors();
      test_reset_mid_frame();
      test_back_to_back();
`ifdef CRC32_CHECK_EN
      test_crc();
`endif
      checks++; if (both_cnt != 0) begin errors++; $display("[TB] FAIL exclusive_pulses: got %0d overlaps expected 0", both_cnt); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
